bus_mux_pipe: RTL and testbench

BUS_MUX_PIPE -- requirements
Module: bus_mux_pipe

---
 rtl/bus_mux_pipe.sv | 133 +++++++++++++
 tb/tb_bus_mux_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_pipe.sv
// One-hot selected bus multiplexer with a single registered output slot and
// valid/ready handshake. Define BUS_MUX_ERRCNT_EN to enable the illegal-select counter.
module bus_mux_pipe #(
  parameter int DATA_W  = 16,
  parameter int NUM_SRC = 10,
  parameter int CNT_W   = 4
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          sel,
  input  logic                        sel_valid,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_SRC)-1:0]  out_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        err_clr,
  output logic                        err_flag,
  output logic [CNT_W-1:0]            err_count
);

  localparam int IDX_W = $clog2(NUM_SRC);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             stateQ;
  state_t             stateD;
  logic               accept;
  logic               selLegal;
  logic               legalAcc;
  logic               illegalAcc;
  logic [IDX_W-1:0]   selIdx;
  logic [DATA_W-1:0]  selWord;
  logic [DATA_W-1:0]  dataQ;
  logic [IDX_W-1:0]   idxQ;
  logic               errFlagQ;

  assign out_valid  = (stateQ == FULL);
  assign in_ready   = !out_valid || out_ready;
  assign accept     = sel_valid && in_ready;
  assign selLegal   = ($countones(sel) == 1);
  assign legalAcc   = accept && selLegal;
  assign illegalAcc = accept && !selLegal;

  // Encoder and AND-OR mux; results are only consumed when sel is one-hot.
  always_comb begin
    selIdx  = '0;
    selWord = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel[k]) begin
        selIdx  = selIdx | IDX_W'(k);
        selWord = selWord | src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      stateQ <= EMPTY;
    end else begin
      stateQ <= stateD;
    end
  end

  // A full slot with out_ready low is a stall; any non-reloading exit empties it.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      EMPTY: begin
        if (legalAcc) begin
          stateD = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          stateD = legalAcc ? FULL : EMPTY;
        end
      end
      default: stateD = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dataQ <= '0;
      idxQ  <= '0;
    end else if (legalAcc) begin
      dataQ <= selWord;
      idxQ  <= selIdx;
    end
  end

  assign out_data = dataQ;
  assign out_idx  = idxQ;

  // A clear that coincides with an illegal accept leaves the new error visible.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      errFlagQ <= 1'b0;
    end else if (err_clr) begin
      errFlagQ <= illegalAcc;
    end else if (illegalAcc) begin
      errFlagQ <= 1'b1;
    end
  end

  assign err_flag = errFlagQ;

`ifdef BUS_MUX_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] errCntQ;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      errCntQ <= '0;
    end else if (err_clr) begin
      errCntQ <= illegalAcc ? CNT_W'(1) : '0;
    end else if (illegalAcc && (errCntQ != CNT_MAX)) begin
      errCntQ <= errCntQ + CNT_W'(1);
    end
  end

  assign err_count = errCntQ;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_bus_mux_pipe.sv
// Self-checking bench for bus_mux_pipe: per-cycle behavioural model comparison
// plus literal checks of the directed scenarios.
module tb_bus_mux_pipe;

  localparam int DATA_W  = 16;
  localparam int NUM_SRC = 10;
  localparam int CNT_W   = 2;
  localparam int IDX_W   = $clog2(NUM_SRC);

  logic                       clock;
  logic                       resetn;
  logic [NUM_SRC*DATA_W-1:0]  src_data;
  logic [NUM_SRC-1:0]         sel;
  logic                       sel_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          out_data;
  logic [IDX_W-1:0]           out_idx;
  logic                       out_valid;
  logic                       out_ready;
  logic                       err_clr;
  logic                       err_flag;
  logic [CNT_W-1:0]           err_count;

  logic [DATA_W-1:0] src [NUM_SRC];

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 0;

  bit          mValid;
  int          mData;
  int          mIdx;
  bit          mFlag;
  int          mCount;

  bus_mux_pipe #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .CNT_W   (CNT_W)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .src_data  (src_data),
    .sel       (sel),
    .sel_valid (sel_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .err_flag  (err_flag),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      src_data[k*DATA_W +: DATA_W] = src[k];
    end
  end

  // Reference model: a one-entry slot plus error bookkeeping.
  always @(posedge clock) begin
    int ones;
    int hit;
    bit acc;
    if (!resetn) begin
      mValid = 0; mData = 0; mIdx = 0; mFlag = 0; mCount = 0;
    end else begin
      acc  = sel_valid && (!mValid || out_ready);
      ones = 0;
      hit  = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (sel[k]) begin
          ones++;
          hit = k;
        end
      end
      if (acc && ones == 1) begin
        mData  = int'(src_data[hit*DATA_W +: DATA_W]);
        mIdx   = hit;
        mValid = 1;
      end else begin
        mValid = mValid && !out_ready;
      end
      if (err_clr) begin
        mFlag = acc && ones != 1;
      end else if (acc && ones != 1) begin
        mFlag = 1;
      end
`ifdef BUS_MUX_ERRCNT_EN
      if (err_clr) begin
        mCount = (acc && ones != 1) ? 1 : 0;
      end else if (acc && ones != 1 && mCount < (1 << CNT_W) - 1) begin
        mCount = mCount + 1;
      end
`else
      mCount = 0;
`endif
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("model out_valid", int'(out_valid), int'(mValid));
      checkOutput("model out_data",  int'(out_data),  mData);
      checkOutput("model out_idx",   int'(out_idx),   mIdx);
      checkOutput("model err_flag",  int'(err_flag),  int'(mFlag));
      checkOutput("model err_count", int'(err_count), mCount);
      checkOutput("model in_ready",  int'(in_ready),  int'(!mValid || out_ready));
    end
  end

  task automatic applyStimulus(input logic sv, input logic [NUM_SRC-1:0] s,
                               input logic ordy, input logic clr);
    sel_valid = sv;
    sel       = s;
    out_ready = ordy;
    err_clr   = clr;
    @(posedge clock);
    #1;
  endtask

  function automatic int expCount(input int n);
`ifdef BUS_MUX_ERRCNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  initial begin
    for (int k = 0; k < NUM_SRC; k++) src[k] = '0;
    src[0]    = 16'h5555;
    resetn    = 1'b0;
    sel_valid = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;

    // Reset held two cycles with a pending request.
    applyStimulus(1'b1, 10'b0000000001, 1'b1, 1'b0);
    applyStimulus(1'b1, 10'b0000000001, 1'b1, 1'b0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_data",  int'(out_data),  16'h0000);
    checkOutput("reset out_idx",   int'(out_idx),   0);
    checkOutput("reset err_flag",  int'(err_flag),  0);
    checkOutput("reset err_count", int'(err_count), 0);
    checkEn = 1;

    // Legal capture then back-to-back reload.
    resetn  = 1'b1;
    src[1]  = 16'h00AB;
    src[9]  = 16'h1234;
    sel_valid = 1'b0;
    #1;
    checkOutput("in_ready after release", int'(in_ready), 1);
    applyStimulus(1'b1, 10'b0000000010, 1'b1, 1'b0);
    checkOutput("cap1 out_data",  int'(out_data),  16'h00AB);
    checkOutput("cap1 out_idx",   int'(out_idx),   1);
    checkOutput("cap1 out_valid", int'(out_valid), 1);
    applyStimulus(1'b1, 10'b1000000000, 1'b1, 1'b0);
    checkOutput("b2b out_data", int'(out_data), 16'h1234);
    checkOutput("b2b out_idx",  int'(out_idx),  9);

    // Reload source 1, then stall three cycles while the source and sel change.
    applyStimulus(1'b1, 10'b0000000010, 1'b1, 1'b0);
    src[1] = 16'hFFFF;
    applyStimulus(1'b1, 10'b0000000011, 1'b0, 1'b0);
    checkOutput("stall in_ready", int'(in_ready), 0);
    applyStimulus(1'b1, 10'b0000000010, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'b0000000000, 1'b0, 1'b0);
    checkOutput("stall out_data",  int'(out_data),  16'h00AB);
    checkOutput("stall out_valid", int'(out_valid), 1);
    checkOutput("stall err_count", int'(err_count), 0);
    applyStimulus(1'b0, 10'b0000000000, 1'b1, 1'b0);
    checkOutput("drain out_valid", int'(out_valid), 0);

    // Illegal selects: two bits, then none.
    applyStimulus(1'b1, 10'b0000000011, 1'b1, 1'b0);
    checkOutput("ill1 out_valid", int'(out_valid), 0);
    checkOutput("ill1 err_flag",  int'(err_flag),  1);
    checkOutput("ill1 err_count", int'(err_count), expCount(1));
    applyStimulus(1'b1, 10'b0000000000, 1'b1, 1'b0);
    checkOutput("ill2 err_count", int'(err_count), expCount(2));
    checkOutput("ill2 out_data",  int'(out_data),  16'h00AB);

    // Illegal accept while full consumes the held word; counter saturates at 3.
    src[2] = 16'h0C0C;
    applyStimulus(1'b1, 10'b0000000100, 1'b1, 1'b0);
    checkOutput("cap2 out_idx", int'(out_idx), 2);
    applyStimulus(1'b1, 10'b0000000101, 1'b1, 1'b0);
    checkOutput("ill3 out_valid", int'(out_valid), 0);
    checkOutput("ill3 out_data",  int'(out_data),  16'h0C0C);
    applyStimulus(1'b1, 10'b0000000000, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'b1111111111, 1'b0, 1'b0);
    checkOutput("sat err_count", int'(err_count), expCount(3));

    // Clear coinciding with an illegal accept, then a plain clear.
    applyStimulus(1'b1, 10'b0000000011, 1'b1, 1'b1);
    checkOutput("clr+ill err_flag",  int'(err_flag),  1);
    checkOutput("clr+ill err_count", int'(err_count), expCount(1));
    applyStimulus(1'b0, 10'b0000000011, 1'b1, 1'b1);
    checkOutput("clr err_flag", int'(err_flag), 0);

    // Reset while stalled discards the word.
    src[3] = 16'h3333;
    applyStimulus(1'b1, 10'b0000001000, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'b0000000000, 1'b0, 1'b0);
    resetn = 1'b0;
    applyStimulus(1'b1, 10'b0000010000, 1'b0, 1'b1);
    checkOutput("rst-stall out_valid", int'(out_valid), 0);
    checkOutput("rst-stall out_data",  int'(out_data),  0);
    resetn = 1'b1;

    // Mixed directed traffic checked by the model only.
    for (int k = 4; k < NUM_SRC; k++) src[k] = 16'(16'hA000 + k);
    applyStimulus(1'b1, 10'b0000010000, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'b0000100000, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'b0000100000, 1'b1, 1'b0);
    applyStimulus(1'b1, 10'b0001000000, 1'b1, 1'b0);
    applyStimulus(1'b1, 10'b0110000000, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'b0100000000, 1'b1, 1'b0);
    applyStimulus(1'b1, 10'b0100000000, 1'b0, 1'b1);
    applyStimulus(1'b1, 10'b1000000000, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'b0000000000, 1'b1, 1'b0);
    @(negedge clock);
    checkEn = 0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
